aes128_encrypt_iterative: RTL

- Iterative AES-128 encryption core (FIPS-197 cipher). Forward-direction counterpart to the team's AES-128 decryptor; pairs with it for loopback test.
- Executes one full round per clock, with on-the-fly key expansion.
- Accepts one 128-bit plaintext/key pair through a valid/ready handshake. Presents the ciphertext, held until the consumer accepts it.

---
 rtl/aes128_encrypt_iterative_if.sv | 21 ++
 rtl/aes128_encrypt_iterative.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_iterative_if.sv
// Handshake bundle for the iterative AES-128 encryptor: plaintext/key in, ciphertext out.
// Vectors are [0:127]; byte n occupies bits [8n:8n+7].
interface aes128_encrypt_iterative_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_text;
    logic [0:127] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_text;

    modport slave (
        input  in_valid, in_text, in_key, out_ready,
        output in_ready, out_valid, out_text
    );

    modport master (
        output in_valid, in_text, in_key, out_ready,
        input  in_ready, out_valid, out_text
    );
endinterface

// File: rtl/aes128_encrypt_iterative.sv
// Iterative AES-128 cipher: one full round per clock with on-the-fly key expansion.
// Accepts a block in IDLE, runs 10 rounds in RUN, holds the ciphertext in DONE.
module aes128_encrypt_iterative (
    input  logic                         clk,
    input  logic                         reset,
    aes128_encrypt_iterative_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One column times the circulant [02 03 01 01].
    function automatic logic [0:31] mix_col(input logic [0:31] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[0 +: 8];
        a1 = col[8 +: 8];
        a2 = col[16 +: 8];
        a3 = col[24 +: 8];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [0:127] state_q, state_d;
    logic [0:127] rkey_q, rkey_d;
    logic [0:127] out_text_q, out_text_d;

    logic [0:127] sub_bytes, shift_rows, mix_cols, next_rkey;
    logic [0:31]  last_word, key_temp;

    always_comb begin
        sub_bytes  = '0;
        shift_rows = '0;
        mix_cols   = '0;
        for (int i = 0; i < 16; i++) begin
            sub_bytes[8*i +: 8] = sbox(state_q[8*i +: 8]);
        end
        // Row r of column c takes the byte from column (c+r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_rows[8*(4*c + r) +: 8] = sub_bytes[8*(4*((c + r) % 4) + r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_cols[32*c +: 32] = mix_col(shift_rows[32*c +: 32]);
        end
    end

    always_comb begin
        last_word = rkey_q[96 +: 32];
        key_temp  = {sbox(last_word[8 +: 8]) ^ rcon(round_q),
                     sbox(last_word[16 +: 8]),
                     sbox(last_word[24 +: 8]),
                     sbox(last_word[0 +: 8])};
        next_rkey            = '0;
        next_rkey[0 +: 32]   = rkey_q[0 +: 32]  ^ key_temp;
        next_rkey[32 +: 32]  = rkey_q[32 +: 32] ^ next_rkey[0 +: 32];
        next_rkey[64 +: 32]  = rkey_q[64 +: 32] ^ next_rkey[32 +: 32];
        next_rkey[96 +: 32]  = rkey_q[96 +: 32] ^ next_rkey[64 +: 32];
    end

    always_comb begin
        fsm_d      = fsm_q;
        round_d    = round_q;
        state_d    = state_q;
        rkey_d     = rkey_q;
        out_text_d = out_text_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.in_text ^ bus.in_key;
                    rkey_d  = bus.in_key;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                rkey_d  = next_rkey;
                round_d = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    state_d    = shift_rows ^ next_rkey;
                    out_text_d = shift_rows ^ next_rkey;
                    fsm_d      = DONE;
                end else begin
                    state_d = mix_cols ^ next_rkey;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q      <= IDLE;
            round_q    <= '0;
            state_q    <= '0;
            rkey_q     <= '0;
            out_text_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            round_q    <= round_d;
            state_q    <= state_d;
            rkey_q     <= rkey_d;
            out_text_q <= out_text_d;
        end
    end

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.out_text  = out_text_q;

endmodule
